// File: rtl/ram_slot_arbiter_if.sv
// Bundle of core, DMA and RAM-side signals around the RAM slot arbiter.
// slave is the arbiter's view; master is the surrounding core/DMA/RAM view.
interface ram_slot_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) ();

  // Core side
  logic          cpu_ce;
  logic [AW-1:0] cpu_addr;
  logic          cpu_rw;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_rdy;
  logic [DW-1:0] cpu_rdata;

  // DMA side
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  // RAM side
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    output cpu_ce,
    input  cpu_addr,
    input  cpu_rw,
    input  cpu_wdata,
    input  cpu_rdy,
    output cpu_rdata,
    input  dma_req,
    input  dma_we,
    input  dma_addr,
    input  dma_wdata,
    output dma_gnt,
    output dma_rvalid,
    output dma_rdata,
    output ram_addr,
    output ram_we,
    output ram_wdata,
    input  ram_rdata
  );

  modport master (
    input  cpu_ce,
    output cpu_addr,
    output cpu_rw,
    output cpu_wdata,
    output cpu_rdy,
    input  cpu_rdata,
    output dma_req,
    output dma_we,
    output dma_addr,
    output dma_wdata,
    input  dma_gnt,
    input  dma_rvalid,
    input  dma_rdata,
    input  ram_addr,
    input  ram_we,
    input  ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/ram_slot_arbiter.sv
// Time-slot arbiter sharing one single-port synchronous RAM between the 6502
// core (fixed ph0 slot, clock enable in ph1) and a DMA requester (ph1 slot plus
// any ph0 slot the core donates while halted on a read).
module ram_slot_arbiter #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) (
  input logic               clk,
  input logic               rst_n,
  ram_slot_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OwnNone,
    OwnCpu,
    OwnDma
  } rd_own_e;

  logic          ph_q;
  rd_own_e       rd_own_q, rd_own_d;
  logic [DW-1:0] cpu_q;
  logic [DW-1:0] dma_rdata_q;

  logic          donate;
  logic          dma_slot;
  logic [AW-1:0] ram_addr_d;
  logic          ram_we_d;
  logic [DW-1:0] ram_wdata_d;
  logic          dma_gnt_d;

  // A halted core only gives up its slot when it is reading; writes must land.
  assign donate   = ~ph_q & ~bus.cpu_rdy & bus.cpu_rw;
  assign dma_slot = ph_q | donate;

  // Slot steering: RAM port mux, DMA grant and read-return tag for this cycle.
  always_comb begin
    ram_addr_d  = bus.cpu_addr;
    ram_we_d    = 1'b0;
    ram_wdata_d = bus.cpu_wdata;
    dma_gnt_d   = 1'b0;
    rd_own_d    = OwnNone;
    if (!dma_slot) begin
      ram_we_d = ~bus.cpu_rw;
      if (bus.cpu_rw) begin
        rd_own_d = OwnCpu;
      end
    end else begin
      ram_addr_d  = bus.dma_addr;
      ram_wdata_d = bus.dma_wdata;
      if (bus.dma_req) begin
        ram_we_d  = bus.dma_we;
        dma_gnt_d = 1'b1;
        if (!bus.dma_we) begin
          rd_own_d = OwnDma;
        end
      end
    end
    // Strobes are forced quiet while reset is held so nothing is written.
    if (!rst_n) begin
      ram_we_d  = 1'b0;
      dma_gnt_d = 1'b0;
    end
  end

  // Phase counter and read-return tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q     <= 1'b0;
      rd_own_q <= OwnNone;
    end else begin
      ph_q     <= ~ph_q;
      rd_own_q <= rd_own_d;
    end
  end

  // Hold registers for returned read data, loaded when the tagged read lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_q       <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (rd_own_q == OwnCpu) begin
        cpu_q <= bus.ram_rdata;
      end
      if (rd_own_q == OwnDma) begin
        dma_rdata_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.ram_addr   = ram_addr_d;
  assign bus.ram_we     = ram_we_d;
  assign bus.ram_wdata  = ram_wdata_d;
  assign bus.dma_gnt    = dma_gnt_d;
  assign bus.cpu_ce     = ph_q;
  // Fresh data bypasses the hold register in the ph1 the core samples it.
  assign bus.cpu_rdata  = (ph_q && (rd_own_q == OwnCpu)) ? bus.ram_rdata : cpu_q;
  assign bus.dma_rvalid = (rd_own_q == OwnDma);
  assign bus.dma_rdata  = (rd_own_q == OwnDma) ? bus.ram_rdata : dma_rdata_q;

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Self-checking bench for ram_slot_arbiter: behavioural RAM, phase model and a
// queue of expected DMA read data popped whenever dma_rvalid is seen.
module tb_ram_slot_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ram_slot_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_slot_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic          tb_ph;

  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] ram_q;

  // Single-port RAM, read-first, registered read data; preload port for setup.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    ram_q <= mem[bus.ram_addr];
  end
  assign bus.ram_rdata = ram_q;

  // Reference phase: 0 out of reset, toggles every clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ph <= 1'b0;
    else tb_ph <= ~tb_ph;
  end

  // Scoreboard: every dma_rvalid must match the oldest expected value.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.dma_rvalid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL dma_rvalid_unexpected: got rvalid=1 data=%h, required rvalid=0",
                   bus.dma_rdata);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.dma_rdata !== mon_exp) begin
            errors++;
            $display("FAIL dma_rdata: got %h, required %h", bus.dma_rdata, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_ph0();
    tick();
    while (tb_ph != 1'b0) tick();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic test_reset_read();
    rst_n = 1'b0;
    bus.cpu_addr = 16'h0000; bus.cpu_rw = 1'b0; bus.cpu_wdata = 8'hEE; bus.cpu_rdy = 1'b1;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0000; bus.dma_wdata = 8'hEE;
    tick();
    @(negedge clk);
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL rst_cpu_ce: got %b, required 0", bus.cpu_ce); end
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL rst_dma_gnt: got %b, required 0", bus.dma_gnt); end
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL rst_dma_rvalid: got %b, required 0", bus.dma_rvalid); end
    checks++; if (bus.dma_rdata !== 8'h00) begin errors++; $display("FAIL rst_dma_rdata: got %h, required 00", bus.dma_rdata); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b, required 0", bus.ram_we); end
    checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL rst_cpu_rdata: got %h, required 00", bus.cpu_rdata); end
    // Release just after an edge so the whole first cycle is ph0.
    tick();
    rst_n = 1'b1;
    bus.cpu_addr = 16'h1234; bus.cpu_rw = 1'b1;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0;
    @(negedge clk);
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL rd_ph0_cpu_ce: got %b, required 0", bus.cpu_ce); end
    checks++; if (bus.ram_addr !== 16'h1234) begin errors++; $display("FAIL rd_ph0_ram_addr: got %h, required 1234", bus.ram_addr); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rd_ph0_ram_we: got %b, required 0", bus.ram_we); end
    tick();
    @(negedge clk);
    checks++; if (bus.cpu_ce !== 1'b1) begin errors++; $display("FAIL rd_ph1_cpu_ce: got %b, required 1", bus.cpu_ce); end
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_ph1_cpu_rdata: got %h, required a5", bus.cpu_rdata); end
    tick();
    @(negedge clk);
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_hold_cpu_q: got %h, required a5", bus.cpu_rdata); end
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      checks++; if (bus.cpu_ce !== tb_ph) begin errors++; $display("FAIL ce_pattern[%0d]: got %b, required %b", i, bus.cpu_ce, tb_ph); end
    end
  endtask

  task automatic test_interleaved();
    to_ph0();
    bus.cpu_addr = 16'h0200; bus.cpu_rw = 1'b0; bus.cpu_wdata = 8'h55; bus.cpu_rdy = 1'b1;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0200;
    exp_q.push_back(8'h55);
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL il_ph0_gnt: got %b, required 0", bus.dma_gnt); end
    checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL il_ph0_ram_we: got %b, required 1", bus.ram_we); end
    checks++; if (bus.ram_addr !== 16'h0200) begin errors++; $display("FAIL il_ph0_ram_addr: got %h, required 0200", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 8'h55) begin errors++; $display("FAIL il_ph0_ram_wdata: got %h, required 55", bus.ram_wdata); end
    tick();
    bus.cpu_rw = 1'b1; bus.cpu_addr = 16'h1234;
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL il_ph1_gnt: got %b, required 1", bus.dma_gnt); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL il_ph1_ram_we: got %b, required 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 16'h0200) begin errors++; $display("FAIL il_ph1_ram_addr: got %h, required 0200", bus.ram_addr); end
    tick();
    bus.dma_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.dma_rvalid !== 1'b1) begin errors++; $display("FAIL il_rvalid: got %b, required 1", bus.dma_rvalid); end
    tick();
    @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL il_pending: got %0d outstanding, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_donation();
    to_ph0();
    // A non-donated read of 0x0200 would overwrite cpu_q with 0x55.
    bus.cpu_addr = 16'h0200; bus.cpu_rw = 1'b1; bus.cpu_rdy = 1'b0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      @(negedge clk);
      checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL don_gnt[%0d]: got %b, required 1", i, bus.dma_gnt); end
      checks++; if (bus.ram_addr !== 16'(i)) begin errors++; $display("FAIL don_ram_addr[%0d]: got %h, required %h", i, bus.ram_addr, 16'(i)); end
      checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL don_cpu_rdata[%0d]: got %h, required a5", i, bus.cpu_rdata); end
      tick();
      bus.dma_addr = 16'(i + 1);
    end
    bus.dma_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL don_cpu_q_a: got %h, required a5", bus.cpu_rdata); end
    tick();
    @(negedge clk);
    checks++; if (bus.cpu_rdata !== 8'hA5) begin errors++; $display("FAIL don_cpu_q_b: got %h, required a5", bus.cpu_rdata); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL don_pending: got %0d outstanding, required 0", exp_q.size()); end
    exp_q.delete();
    bus.cpu_rdy = 1'b1; bus.cpu_addr = 16'h1234;
  endtask

  task automatic test_no_donate_write();
    to_ph0();
    bus.cpu_addr = 16'h0300; bus.cpu_rw = 1'b0; bus.cpu_wdata = 8'h77; bus.cpu_rdy = 1'b0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0300;
    exp_q.push_back(8'h77);
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL nd_ph0_gnt: got %b, required 0", bus.dma_gnt); end
    checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL nd_ph0_ram_we: got %b, required 1", bus.ram_we); end
    checks++; if (bus.ram_addr !== 16'h0300) begin errors++; $display("FAIL nd_ph0_ram_addr: got %h, required 0300", bus.ram_addr); end
    checks++; if (bus.ram_wdata !== 8'h77) begin errors++; $display("FAIL nd_ph0_ram_wdata: got %h, required 77", bus.ram_wdata); end
    tick();
    bus.cpu_rw = 1'b1; bus.cpu_rdy = 1'b1; bus.cpu_addr = 16'h1234;
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL nd_ph1_gnt: got %b, required 1", bus.dma_gnt); end
    tick();
    bus.dma_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.dma_rvalid !== 1'b1) begin errors++; $display("FAIL nd_rvalid: got %b, required 1", bus.dma_rvalid); end
    tick();
    @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL nd_pending: got %0d outstanding, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_read();
    to_ph0();
    bus.cpu_addr = 16'h1234; bus.cpu_rw = 1'b1; bus.cpu_rdy = 1'b1;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0003;
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL rm_ph0_gnt: got %b, required 0", bus.dma_gnt); end
    tick();
    // Halting the core now would donate the next ph0 if reset did not gate it.
    bus.cpu_rdy = 1'b0;
    @(negedge clk);
    checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL rm_ph1_gnt: got %b, required 1", bus.dma_gnt); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid: got %b, required 0", bus.dma_rvalid); end
    checks++; if (bus.dma_rdata !== 8'h00) begin errors++; $display("FAIL rm_dma_rdata: got %h, required 00", bus.dma_rdata); end
    checks++; if (bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL rm_cpu_rdata: got %h, required 00", bus.cpu_rdata); end
    checks++; if (bus.cpu_ce !== 1'b0) begin errors++; $display("FAIL rm_cpu_ce: got %b, required 0", bus.cpu_ce); end
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL rm_dma_gnt: got %b, required 0", bus.dma_gnt); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rm_ram_we: got %b, required 0", bus.ram_we); end
    bus.dma_req = 1'b0; bus.cpu_rdy = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rm_pending: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_idle_dma();
    to_ph0();
    bus.cpu_addr = 16'h1234; bus.cpu_rw = 1'b1; bus.cpu_rdy = 1'b1;
    bus.dma_req = 1'b0; bus.dma_we = 1'b1; bus.dma_addr = 16'h0000; bus.dma_wdata = 8'hEE;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL idle_gnt[%0d]: got %b, required 0", i, bus.dma_gnt); end
      if (tb_ph == 1'b1) begin
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL idle_ram_we[%0d]: got %b, required 0", i, bus.ram_we); end
      end
      tick();
    end
  endtask

  initial begin
    bus.cpu_addr = '0; bus.cpu_rw = 1'b1; bus.cpu_wdata = '0; bus.cpu_rdy = 1'b1;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    rst_n = 1'b0;
    preload(16'h1234, 8'hA5);
    preload(16'h0000, 8'h10);
    preload(16'h0001, 8'h11);
    preload(16'h0002, 8'h12);
    preload(16'h0003, 8'h13);
    test_reset_read();
    test_interleaved();
    test_donation();
    test_no_donate_write();
    test_reset_mid_read();
    test_idle_dma();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
